// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_pkg
// Description : Shared encodings, state type and defaults for the USB
//               transmit-side packet scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    // External bit-select mux encodings, one per packet source
    localparam logic [1:0] SEL_TOKEN  = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b11;
    localparam logic [1:0] SEL_HSHAKE = 2'b10;

    // Default run length of 1s that forces a stuffed 0
    localparam int         STUFF_LEN_DEF = 6;

    // Default SYNC field, transmitted LSB first: 0,0,0,0,0,0,0,1
    localparam logic [7:0] SYNC_PAT_DEF  = 8'h80;

    // Packet sequencing states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SYNC       = 3'd1,
        ST_PAYLOAD    = 3'd2,
        ST_STUFF_TAIL = 3'd3,
        ST_EOP        = 3'd4,
        ST_EOP_J      = 3'd5
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/usb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module      : usb_bit_stuffer
// Description : Tracks the run of consecutive transmitted 1s and flags when
//               the next bit-time must carry a stuffed 0.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic bit_in,
    input  logic load_one,
    input  logic clear,
    output logic stuff_now,
    output logic stuff_next
);

    localparam logic [2:0] c_LIMIT    = 3'(STUFF_LEN);
    localparam logic [2:0] c_LIMIT_M1 = 3'(STUFF_LEN - 1);

    logic [2:0] r_ones_cnt;

    // Run-length counter: seeded with 1 after SYNC, reset by a stuff bit or a 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ones_cnt <= 3'd0;
        end else if (bit_en) begin
            if (load_one) begin
                r_ones_cnt <= 3'd1;
            end else if (clear) begin
                r_ones_cnt <= 3'd0;
            end else if (stuff_now) begin
                r_ones_cnt <= 3'd0;
            end else if (bit_in) begin
                r_ones_cnt <= r_ones_cnt + 3'd1;
            end else begin
                r_ones_cnt <= 3'd0;
            end
        end
    end

    // stuff_now: this bit-time is a stuff bit; stuff_next: consuming bit_in
    // now completes a run, so the following bit-time must be stuffed
    always_comb begin
        stuff_now  = (r_ones_cnt == c_LIMIT);
        stuff_next = !stuff_now && bit_in && (r_ones_cnt == c_LIMIT_M1);
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sched
// Description : Arbitrates handshake/token/data sources onto one serial
//               transmit lane and sequences SYNC, stuffed payload and EOP.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sched
    import usb_tx_pkg::*;
#(
    parameter int         STUFF_LEN = STUFF_LEN_DEF,
    parameter logic [7:0] SYNC_PAT  = SYNC_PAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       hs_req,
    input  logic       tok_req,
    input  logic       data_req,
    input  logic       hs_last,
    input  logic       tok_last,
    input  logic       data_last,
    input  logic       src_bit,
    output logic [1:0] sel,
    output logic       hs_rd,
    output logic       tok_rd,
    output logic       data_rd,
    output logic       tx_bit,
    output logic       tx_se0,
    output logic       tx_oe,
    output logic       busy,
    output logic       done
);

    tx_state_t  r_state, w_state_nxt;
    logic [1:0] r_sel, w_sel_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_eop, w_eop_nxt;
    logic       r_tx_bit, w_tx_bit_nxt;
    logic       r_tx_se0, w_tx_se0_nxt;
    logic       r_tx_oe, w_tx_oe_nxt;
    logic       r_done, w_done_nxt;

    logic       w_load_one;
    logic       w_consume;
    logic       w_last;
    logic       w_stuff_clear;
    logic       w_stuff_now;
    logic       w_stuff_next;

    // Outside PAYLOAD the run counter is forced to zero; the SYNC exit seeds it
    assign w_stuff_clear = (r_state != ST_PAYLOAD);

    usb_bit_stuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_stuffer (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .bit_in     (src_bit),
        .load_one   (w_load_one),
        .clear      (w_stuff_clear),
        .stuff_now  (w_stuff_now),
        .stuff_next (w_stuff_next)
    );

    // Final-bit flag of whichever source currently holds the grant
    always_comb begin
        case (r_sel)
            SEL_HSHAKE: w_last = hs_last;
            SEL_TOKEN:  w_last = tok_last;
            SEL_DATA:   w_last = data_last;
            default:    w_last = 1'b0;
        endcase
    end

    // Next-state and next-output logic; everything holds unless bit_en is high
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_eop_nxt    = r_eop;
        w_tx_bit_nxt = r_tx_bit;
        w_tx_se0_nxt = r_tx_se0;
        w_tx_oe_nxt  = r_tx_oe;
        w_done_nxt   = 1'b0;
        w_load_one   = 1'b0;
        w_consume    = 1'b0;

        if (bit_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_tx_bit_nxt = 1'b1;
                    w_tx_se0_nxt = 1'b0;
                    w_tx_oe_nxt  = 1'b0;
                    // Requests only matter here; the grant is frozen until done
                    if (hs_req) begin
                        w_sel_nxt   = SEL_HSHAKE;
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = 3'd0;
                    end else if (tok_req) begin
                        w_sel_nxt   = SEL_TOKEN;
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = 3'd0;
                    end else if (data_req) begin
                        w_sel_nxt   = SEL_DATA;
                        w_state_nxt = ST_SYNC;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                ST_SYNC: begin
                    w_tx_bit_nxt = SYNC_PAT[r_cnt];
                    w_tx_se0_nxt = 1'b0;
                    w_tx_oe_nxt  = 1'b1;
                    w_cnt_nxt    = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        // SYNC ends in a 1, which counts toward the first stuff run
                        w_state_nxt = ST_PAYLOAD;
                        w_load_one  = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    w_tx_se0_nxt = 1'b0;
                    w_tx_oe_nxt  = 1'b1;
                    if (w_stuff_now) begin
                        // Stuff bit: source is not popped and its last flag is ignored
                        w_tx_bit_nxt = 1'b0;
                    end else begin
                        w_tx_bit_nxt = src_bit;
                        w_consume    = 1'b1;
                        if (w_last) begin
                            w_eop_nxt   = 1'b0;
                            w_state_nxt = w_stuff_next ? ST_STUFF_TAIL : ST_EOP;
                        end
                    end
                end
                ST_STUFF_TAIL: begin
                    w_tx_bit_nxt = 1'b0;
                    w_tx_se0_nxt = 1'b0;
                    w_tx_oe_nxt  = 1'b1;
                    w_eop_nxt    = 1'b0;
                    w_state_nxt  = ST_EOP;
                end
                ST_EOP: begin
                    w_tx_bit_nxt = 1'b0;
                    w_tx_se0_nxt = 1'b1;
                    w_tx_oe_nxt  = 1'b1;
                    w_eop_nxt    = r_eop + 1'b1;
                    if (r_eop) begin
                        w_state_nxt = ST_EOP_J;
                    end
                end
                ST_EOP_J: begin
                    w_tx_bit_nxt = 1'b1;
                    w_tx_se0_nxt = 1'b0;
                    w_tx_oe_nxt  = 1'b1;
                    w_state_nxt  = ST_IDLE;
                    w_done_nxt   = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Pop strobes to the granted source; suppressed while reset is applied
    always_comb begin
        hs_rd   = w_consume && !rst && (r_sel == SEL_HSHAKE);
        tok_rd  = w_consume && !rst && (r_sel == SEL_TOKEN);
        data_rd = w_consume && !rst && (r_sel == SEL_DATA);
    end

    // State, grant, counters and line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= SEL_TOKEN;
            r_cnt    <= 3'd0;
            r_eop    <= 1'b0;
            r_tx_bit <= 1'b1;
            r_tx_se0 <= 1'b0;
            r_tx_oe  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_eop    <= w_eop_nxt;
            r_tx_bit <= w_tx_bit_nxt;
            r_tx_se0 <= w_tx_se0_nxt;
            r_tx_oe  <= w_tx_oe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign sel    = r_sel;
    assign tx_bit = r_tx_bit;
    assign tx_se0 = r_tx_se0;
    assign tx_oe  = r_tx_oe;
    assign done   = r_done;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_sched
// Description : Directed self-checking bench for usb_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       hs_req, tok_req, data_req;
    logic       hs_last, tok_last, data_last;
    logic       src_bit;
    logic [1:0] sel;
    logic       hs_rd, tok_rd, data_rd;
    logic       tx_bit, tx_se0, tx_oe, busy, done;

    int tests = 0;
    int fails = 0;

    // bit-time generator control
    bit en_run = 1'b1;
    int ph = 0;

    // source models: payload, length, and base of the pop counter
    logic [15:0] hs_pl = '0, tok_pl = '0, data_pl = '0;
    int hs_n = 1, tok_n = 1, data_n = 1;
    int hs_base = 0, tok_base = 0, data_base = 0;

    // monitor-owned counters and logs
    int hs_cnt = 0, tok_cnt = 0, data_cnt = 0, done_cnt = 0;
    bit p_hs = 0, p_tok = 0, p_data = 0;
    bit en_prev = 0, busy_prev = 0;
    string cap = "";
    string full = "";
    logic [1:0] grants[$];

    usb_tx_sched dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .hs_req    (hs_req),
        .tok_req   (tok_req),
        .data_req  (data_req),
        .hs_last   (hs_last),
        .tok_last  (tok_last),
        .data_last (data_last),
        .src_bit   (src_bit),
        .sel       (sel),
        .hs_rd     (hs_rd),
        .tok_rd    (tok_rd),
        .data_rd   (data_rd),
        .tx_bit    (tx_bit),
        .tx_se0    (tx_se0),
        .tx_oe     (tx_oe),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // bit_en: one clk in four, changed 2 time units after the edge
    initial begin
        bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (en_run) begin
                ph = (ph + 1) % 4;
                bit_en = (ph == 0);
            end else begin
                bit_en = 1'b0;
            end
        end
    end

    function automatic logic pick(input logic [15:0] pl, input int idx);
        if (idx >= 0 && idx < 16) return pl[idx];
        return 1'b0;
    endfunction

    // external select mux and per-source last flags
    always_comb begin
        hs_last   = ((hs_cnt - hs_base) == hs_n - 1);
        tok_last  = ((tok_cnt - tok_base) == tok_n - 1);
        data_last = ((data_cnt - data_base) == data_n - 1);
        case (sel)
            2'b10:   src_bit = pick(hs_pl, hs_cnt - hs_base);
            2'b01:   src_bit = pick(tok_pl, tok_cnt - tok_base);
            2'b11:   src_bit = pick(data_pl, data_cnt - data_base);
            default: src_bit = 1'b0;
        endcase
    end

    // pop strobes are sampled mid-cycle, before the edge that consumes them
    always @(negedge clk) begin
        en_prev = bit_en && !rst;
        p_hs    = hs_rd;
        p_tok   = tok_rd;
        p_data  = data_rd;
    end

    // after each edge: log line symbols, done pulses, grants, and advance sources
    always @(posedge clk) begin
        #1;
        if (en_prev) begin
            if (!tx_oe)      full = {full, "i"};
            else if (tx_se0) begin cap = {cap, "S"}; full = {full, "S"}; end
            else if (tx_bit) begin cap = {cap, "1"}; full = {full, "1"}; end
            else             begin cap = {cap, "0"}; full = {full, "0"}; end
        end
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && !busy_prev) grants.push_back(sel);
        busy_prev = (busy === 1'b1);
        if (p_hs)   hs_cnt++;
        if (p_tok)  tok_cnt++;
        if (p_data) data_cnt++;
        p_hs = 0; p_tok = 0; p_data = 0;
    end

    task automatic step;
        @(posedge clk);
        #3;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (done_cnt < target) begin
            step();
            n++;
            if (n > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tests++; if (tx_bit !== 1'b1) begin fails++; $display("FAIL reset_tx_bit got %b want 1", tx_bit); end
        tests++; if (tx_se0 !== 1'b0) begin fails++; $display("FAIL reset_tx_se0 got %b want 0", tx_se0); end
        tests++; if (tx_oe !== 1'b0) begin fails++; $display("FAIL reset_tx_oe got %b want 0", tx_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (sel !== 2'b01) begin fails++; $display("FAIL reset_sel got %b want 01", sel); end
        tests++; if ({hs_rd, tok_rd, data_rd} !== 3'b000) begin fails++; $display("FAIL reset_rd got %b want 000", {hs_rd, tok_rd, data_rd}); end
        repeat (8) step();
        tests++; if (tx_oe !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL idle_no_req got oe=%b busy=%b want 0 0", tx_oe, busy); end
    endtask

    task automatic test_token;
        int c0, d0, r0;
        bit ok;
        string got;
        tok_pl = 16'h2D00; tok_n = 16; tok_base = tok_cnt;
        c0 = cap.len(); d0 = done_cnt; r0 = tok_cnt;
        tok_req = 1'b1;
        wait_done(d0 + 1, 400, ok);
        tok_req = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL token_done_timeout got done=%0d want %0d", done_cnt, d0 + 1); end
        got = cap.substr(c0, cap.len() - 1);
        tests++; if (got != "000000010000000010110100SS1") begin fails++; $display("FAIL token_seq got %s want 000000010000000010110100SS1", got); end
        tests++; if (got.len() != 27) begin fails++; $display("FAIL token_bit_times got %0d want 27", got.len()); end
        tests++; if (tok_cnt - r0 != 16) begin fails++; $display("FAIL token_rd_count got %0d want 16", tok_cnt - r0); end
        repeat (6) step();
        tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL token_done_count got %0d want %0d", done_cnt - d0, 1); end
    endtask

    task automatic test_data_stuff;
        int c0, d0, r0;
        bit ok;
        string got;
        data_pl = 16'h00FF; data_n = 8; data_base = data_cnt;
        c0 = cap.len(); d0 = done_cnt; r0 = data_cnt;
        data_req = 1'b1;
        wait_done(d0 + 1, 400, ok);
        data_req = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL data_done_timeout got done=%0d want %0d", done_cnt, d0 + 1); end
        got = cap.substr(c0, cap.len() - 1);
        tests++; if (got != "00000001111110111SS1") begin fails++; $display("FAIL data_stuff_seq got %s want 00000001111110111SS1", got); end
        tests++; if (data_cnt - r0 != 8) begin fails++; $display("FAIL data_rd_count got %0d want 8", data_cnt - r0); end
        repeat (6) step();
    endtask

    task automatic test_hs_tail;
        int c0, d0, r0;
        bit ok;
        string got;
        hs_pl = 16'h00FC; hs_n = 8; hs_base = hs_cnt;
        c0 = cap.len(); d0 = done_cnt; r0 = hs_cnt;
        hs_req = 1'b1;
        wait_done(d0 + 1, 400, ok);
        hs_req = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL hs_done_timeout got done=%0d want %0d", done_cnt, d0 + 1); end
        got = cap.substr(c0, cap.len() - 1);
        tests++; if (got != "00000001001111110SS1") begin fails++; $display("FAIL hs_tail_seq got %s want 00000001001111110SS1", got); end
        tests++; if (hs_cnt - r0 != 8) begin fails++; $display("FAIL hs_rd_count got %0d want 8", hs_cnt - r0); end
        repeat (6) step();
    endtask

    task automatic test_simultaneous;
        int f0, d0, g0;
        bit ok, all_ok;
        string got;
        string exp;
        hs_pl = 16'h0002;   hs_n = 2;   hs_base = hs_cnt;
        tok_pl = 16'h0001;  tok_n = 1;  tok_base = tok_cnt;
        data_pl = 16'h0000; data_n = 1; data_base = data_cnt;
        f0 = full.len(); d0 = done_cnt; g0 = grants.size();
        all_ok = 1'b1;
        hs_req = 1'b1; tok_req = 1'b1; data_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_done(d0 + k, 400, ok);
            if (!ok) all_ok = 1'b0;
            case (sel)
                2'b10:   hs_req = 1'b0;
                2'b01:   tok_req = 1'b0;
                default: data_req = 1'b0;
            endcase
        end
        hs_req = 1'b0; tok_req = 1'b0; data_req = 1'b0;
        tests++; if (!all_ok) begin fails++; $display("FAIL simul_done_timeout got done=%0d want %0d", done_cnt - d0, 3); end
        got = full.substr(f0, full.len() - 1);
        exp = "i0000000101SS1i000000011SS1i000000010SS1";
        tests++; if (got != exp) begin fails++; $display("FAIL simul_seq got %s want %s", got, exp); end
        tests++;
        if (grants.size() < g0 + 3) begin
            fails++; $display("FAIL simul_grants got %0d grants want 3", grants.size() - g0);
        end else if ({grants[g0], grants[g0 + 1], grants[g0 + 2]} !== 6'b10_01_11) begin
            fails++; $display("FAIL simul_grants got %b want 100111", {grants[g0], grants[g0 + 1], grants[g0 + 2]});
        end
        repeat (6) step();
        tests++; if (done_cnt != d0 + 3) begin fails++; $display("FAIL simul_done_count got %0d want 3", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int c0, d0, r0, n;
        bit ok;
        string got;
        data_pl = 16'h00FF; data_n = 8; data_base = data_cnt;
        d0 = done_cnt; r0 = data_cnt;
        data_req = 1'b1;
        n = 0;
        while (data_cnt - r0 < 3 && n < 400) begin step(); n++; end
        tests++; if (data_cnt - r0 != 3) begin fails++; $display("FAIL rstmid_reach got %0d want 3", data_cnt - r0); end
        rst = 1'b1;
        step();
        tests++; if (tx_oe !== 1'b0) begin fails++; $display("FAIL rstmid_tx_oe got %b want 0", tx_oe); end
        tests++; if (tx_bit !== 1'b1) begin fails++; $display("FAIL rstmid_tx_bit got %b want 1", tx_bit); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
        tests++; if (tx_se0 !== 1'b0) begin fails++; $display("FAIL rstmid_tx_se0 got %b want 0", tx_se0); end
        tests++; if (data_cnt - r0 != 3) begin fails++; $display("FAIL rstmid_no_rd got %0d want 3", data_cnt - r0); end
        // restart the source from its first bit for the fresh packet
        data_base = data_cnt; r0 = data_cnt; c0 = cap.len();
        rst = 1'b0;
        wait_done(d0 + 1, 400, ok);
        data_req = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL rstmid_restart_timeout got done=%0d want %0d", done_cnt - d0, 1); end
        got = cap.substr(c0, cap.len() - 1);
        tests++; if (got != "00000001111110111SS1") begin fails++; $display("FAIL rstmid_restart_seq got %s want 00000001111110111SS1", got); end
        tests++; if (data_cnt - r0 != 8) begin fails++; $display("FAIL rstmid_restart_rd got %0d want 8", data_cnt - r0); end
        repeat (6) step();
        tests++; if (done_cnt != d0 + 1) begin fails++; $display("FAIL rstmid_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_bit_en_stall;
        int c0, d0, r0, n;
        bit ok;
        string got;
        tok_pl = 16'h2D00; tok_n = 16; tok_base = tok_cnt;
        c0 = cap.len(); d0 = done_cnt; r0 = tok_cnt;
        tok_req = 1'b1;
        n = 0;
        while (tok_cnt - r0 < 6 && n < 400) begin step(); n++; end
        en_run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            tests++; if (tx_bit !== 1'b0) begin fails++; $display("FAIL stall_tx_bit clk %0d got %b want 0", k, tx_bit); end
            tests++; if (sel !== 2'b01) begin fails++; $display("FAIL stall_sel clk %0d got %b want 01", k, sel); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy clk %0d got %b want 1", k, busy); end
            tests++; if ({hs_rd, tok_rd, data_rd} !== 3'b000) begin fails++; $display("FAIL stall_rd clk %0d got %b want 000", k, {hs_rd, tok_rd, data_rd}); end
        end
        tests++; if (tok_cnt - r0 != 6) begin fails++; $display("FAIL stall_rd_count got %0d want 6", tok_cnt - r0); end
        en_run = 1'b1;
        wait_done(d0 + 1, 400, ok);
        tok_req = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL stall_done_timeout got done=%0d want %0d", done_cnt - d0, 1); end
        got = cap.substr(c0, cap.len() - 1);
        tests++; if (got != "000000010000000010110100SS1") begin fails++; $display("FAIL stall_resume_seq got %s want 000000010000000010110100SS1", got); end
        tests++; if (tok_cnt - r0 != 16) begin fails++; $display("FAIL stall_resume_rd got %0d want 16", tok_cnt - r0); end
        repeat (6) step();
    endtask

    // run-time guard so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        hs_req = 1'b0; tok_req = 1'b0; data_req = 1'b0;
        repeat (5) step();
        test_reset();
        test_token();
        test_data_stuff();
        test_hs_tail();
        test_simultaneous();
        test_reset_mid();
        test_bit_en_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_tx_sched.md
# usb_tx_sched

Transmit-side packet scheduler for the USB serial path. Three packet sources (handshake, token, data) share one serial transmit lane. The block arbitrates between them and drives the external token/data/handshake bit-select mux. It then sequences each packet as SYNC, source payload with bit stuffing, and EOP, and pulls bits from the granted source's PISO/FIFO one bit-time at a time. It sits between the per-packet-type shift/FIFO datapaths and the NRZI/line driver.

## Interface
- `STUFF_LEN`, default 6: consecutive 1s that force a stuffed 0.
- `SYNC_PAT`, default 8'h80: SYNC field, sent LSB first (0,0,0,0,0,0,0,1).
- `clk`, in, 1: single clock. All logic is on posedge.
- `rst`, in, 1: reset, synchronous, active-high.
- `bit_en`, in, 1: one-cycle bit-time strobe. All state advances only on cycles where `bit_en`=1.
- `hs_req`, `tok_req`, `data_req`, in, 1 each: packet pending. Each is held until `done`.
- `hs_last`, `tok_last`, `data_last`, in, 1 each: the source's current bit is its final payload bit.
- `src_bit`, in, 1: current payload bit of the granted source, returned through the external select mux.
- `sel`, out, 2: mux select. 2'b01 token, 2'b11 data, 2'b10 handshake.
- `hs_rd`, `tok_rd`, `data_rd`, out, 1 each: pop one bit from that source. Combinational, at most one high.
- `tx_bit`, out, 1: serial bit to the line encoder. Registered.
- `tx_se0`, out, 1: drive SE0 (EOP). Registered.
- `tx_oe`, out, 1: transmitter enable. Registered.
- `busy`, out, 1: a packet is in progress (state ≠ IDLE).
- `done`, out, 1: one-clk pulse when the packet finishes.

## Operation
- States: IDLE, SYNC, PAYLOAD, STUFF_TAIL, EOP, EOP_J.
- **Reset values:** state IDLE, `sel`=2'b01, `tx_bit`=1, `tx_se0`=0, `tx_oe`=0, `busy`=0, `done`=0, all `*_rd`=0, counters 0.
- **IDLE:** on `bit_en` with any request, latch the grant and set `sel`. Fixed priority is handshake > token > data. Go to SYNC with bit counter = 0. Requests are sampled only here. The grant is held for the whole packet, and request changes mid-packet are ignored.
- **SYNC:** each `bit_en` emits `SYNC_PAT[cnt]` with `tx_oe`=1.
  - After bit 7, go to PAYLOAD with `ones_cnt`=1, because the SYNC's trailing 1 counts toward stuffing.
- **PAYLOAD, on each `bit_en`:**
  - If `ones_cnt`==`STUFF_LEN`: emit 0, set `ones_cnt`=0, no `*_rd`.
  - Otherwise: emit `src_bit` and assert the granted `*_rd` in that same cycle. Set `ones_cnt` = `src_bit` ? `ones_cnt`+1 : 0.
  - If the granted `*_last`=1 on a consumed bit: go to STUFF_TAIL if the new `ones_cnt`==`STUFF_LEN`, else go to EOP.
- **STUFF_TAIL:** emit a stuffed 0, then go to EOP.
- **EOP:** 2 bit-times with `tx_se0`=1, `tx_oe`=1, `tx_bit`=0.
- **EOP_J:** 1 bit-time with `tx_bit`=1, `tx_se0`=0, `tx_oe`=1. Then go to IDLE, set `tx_oe`=0, and pulse `done` for 1 clk.
- **Widths:** SYNC bit counter 3 bits; `ones_cnt` 3 bits, saturating at `STUFF_LEN` only transiently; EOP counter 1 bit.

## Timing
- `tx_*` update at the edge ending a `bit_en` cycle. With `bit_en`=0, outputs and state hold, and `*_rd`=0.
- Latency: request (seen on a `bit_en` in IDLE) to first SYNC bit on `tx_bit` is 1 bit-time.
- Total bit-times per packet = 8 + N payload + S stuffed + 3.
- `*_rd` is valid only while `bit_en`=1. The source must present its next bit and `*_last` before the next `bit_en`.
- Simultaneous requests: the lower-priority source keeps waiting, and it is serviced at the next IDLE `bit_en` after `done`. There is a minimum of 1 idle bit-time between packets.
- `rst` mid-packet: next edge returns to IDLE with reset outputs. No `done` pulse and no `*_rd`.
- `*_last` on a stuff-bit cycle is ignored; the source bit is not consumed.

## Structure
- Package `usb_tx_pkg` holds:
  - `sel` encodings TOKEN=2'b01, DATA=2'b11, HSHAKE=2'b10;
  - the state enum typedef;
  - `SYNC_PAT` and `STUFF_LEN` defaults.
- Sub-module `usb_bit_stuffer` holds `ones_cnt` and the stuff decision.
  - Inputs: `bit_en`, bit, load-1, clear.
  - Output: `stuff_now`.
- The FSM, arbiter and EOP counter live in the top level.

## Test plan
- Token only, 16-bit payload 16'h2D00 (no run of six 1s), `bit_en` every 4 clks:
  - `tx_bit` shows SYNC 0000_0001, then 16 payload bits, then SE0, SE0, J;
  - 16 `tok_rd` pulses and 1 `done`; 27 bit-times total.
- Data payload 8'hFF with `data_last` on bit 8:
  - the SYNC 1 plus five payload 1s cause a 0 to be stuffed after the 5th payload bit;
  - after the last bit the count reaches 3, so no tail stuff; 8 `data_rd`.
- Handshake payload 8'b1111_1100 sent LSB first, ending with six 1s (`hs_last` on the sixth):
  - STUFF_TAIL emits a 0 before EOP.
- `hs_req`, `tok_req` and `data_req` raised in the same cycle:
  - `sel`=2'b10 first, then 2'b01, then 2'b11;
  - three `done` pulses, each packet separated by ≥1 idle bit-time.
- `rst`=1 at payload bit 4:
  - next edge gives `tx_oe`=0, `tx_bit`=1, `busy`=0, no `done`;
  - a fresh request afterwards restarts from SYNC.
- `bit_en` held low for 10 clks mid-payload:
  - `tx_bit`, `sel` and state frozen, no `*_rd`;
  - resumes correctly afterwards.
